// File: rtl/chip8_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : chip8_mem_pkg
//  Description : Shared widths, FSM state encoding and requester indices for
//                the CHIP-8 BRAM port-A arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package chip8_mem_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;

    // Arbiter FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    // Requester indices
    localparam int REQ_CPU = 0;
    localparam int REQ_SPR = 1;

endpackage : chip8_mem_pkg
`default_nettype wire

// File: rtl/chip8_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : chip8_mem_arbiter
//  Description : Two-requester arbiter (CPU = r0, sprite/loader = r1) in front
//                of BRAM port A. Registered owner FSM, per-owner burst limit,
//                registered read-valid routing (1-cycle BRAM latency).
//                Optional macro MEM_ARB_RR_EN: round-robin tie-break in IDLE;
//                without it r0 always wins a tie.
//  Revision    : 1.0 - initial release
// ============================================================================
module chip8_mem_arbiter
    import chip8_mem_pkg::*;
#(
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_rvalid,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_rvalid,
    output logic              mem_en,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [7:0] BURST_LIM = 8'(MAX_BURST - 1);

    logic [1:0]        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [1:0]        pend_q, pend_d;
    logic [1:0]        tie_winner;

    logic              own_valid;
    logic              own_req;
    logic              own_we;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_wdata;
    logic              oth_req;
    logic [1:0]        oth_state;

`ifdef MEM_ARB_RR_EN
    logic last_q, last_d;

    // Remember which requester owned the port most recently for tie-breaks
    always_comb begin
        last_d = last_q;
        if (state_q == ST_OWN0) last_d = 1'b0;
        if (state_q == ST_OWN1) last_d = 1'b1;
        tie_winner = last_q ? ST_OWN0 : ST_OWN1;
    end

    // Last-owner register; resets to r1 so the CPU wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= 1'b1;
        else        last_q <= last_d;
    end
`else
    // Fixed priority: the CPU wins every tie
    always_comb tie_winner = ST_OWN0;
`endif

    // Select the owner's request lines and the other requester's req
    always_comb begin
        own_valid = 1'b0;
        own_req   = 1'b0;
        own_we    = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        oth_req   = 1'b0;
        oth_state = ST_IDLE;
        case (state_q)
            ST_OWN0: begin
                own_valid = 1'b1;
                own_req   = r0_req;
                own_we    = r0_we;
                own_addr  = r0_addr;
                own_wdata = r0_wdata;
                oth_req   = r1_req;
                oth_state = ST_OWN1;
            end
            ST_OWN1: begin
                own_valid = 1'b1;
                own_req   = r1_req;
                own_we    = r1_we;
                own_addr  = r1_addr;
                own_wdata = r1_wdata;
                oth_req   = r0_req;
                oth_state = ST_OWN0;
            end
            default: ;
        endcase
    end

    // Grants, memory port drive and read-data routing
    always_comb begin
        r0_gnt    = (state_q == ST_OWN0) && r0_req;
        r1_gnt    = (state_q == ST_OWN1) && r1_req;
        mem_en    = own_valid && own_req;
        mem_write = own_valid && own_req && own_we;
        mem_addr  = own_addr;
        mem_wdata = own_wdata;
        pend_d          = '0;
        pend_d[REQ_CPU] = r0_gnt && !r0_we;
        pend_d[REQ_SPR] = r1_gnt && !r1_we;
        r0_rvalid = pend_q[REQ_CPU];
        r1_rvalid = pend_q[REQ_SPR];
        r0_rdata  = pend_q[REQ_CPU] ? mem_rdata : '0;
        r1_rdata  = pend_q[REQ_SPR] ? mem_rdata : '0;
    end

    // Owner FSM with burst limit: yield only when someone else is waiting
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (r0_req && r1_req) state_d = tie_winner;
                else if (r0_req)      state_d = ST_OWN0;
                else if (r1_req)      state_d = ST_OWN1;
            end
            ST_OWN0, ST_OWN1: begin
                if (!own_req) begin
                    // Owner released: hand over directly, no IDLE bubble
                    state_d = oth_req ? oth_state : ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == BURST_LIM && oth_req) begin
                    state_d = oth_state;
                    cnt_d   = '0;
                end else if (cnt_q != BURST_LIM) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, burst counter and pending-read flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

endmodule : chip8_mem_arbiter
`default_nettype wire

// File: tb/tb_chip8_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_chip8_mem_arbiter
//  Description : Self-checking bench for chip8_mem_arbiter (MAX_BURST = 4)
//                with a behavioural BRAM and a cycle-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_chip8_mem_arbiter;

    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req [2];
    logic        we  [2];
    logic [11:0] ad  [2];
    logic [7:0]  wd  [2];
    logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
    logic [7:0]  r0_rdata, r1_rdata;
    logic        mem_en, mem_write;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    int n_pass  = 0;
    int n_total = 0;

    chip8_mem_arbiter #(.MAX_BURST(MAXB)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req(req[0]), .r0_we(we[0]), .r0_addr(ad[0]), .r0_wdata(wd[0]),
        .r0_gnt(r0_gnt), .r0_rdata(r0_rdata), .r0_rvalid(r0_rvalid),
        .r1_req(req[1]), .r1_we(we[1]), .r1_addr(ad[1]), .r1_wdata(wd[1]),
        .r1_gnt(r1_gnt), .r1_rdata(r1_rdata), .r1_rvalid(r1_rvalid),
        .mem_en(mem_en), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Power-up content of the BRAM (font byte at 0x050 is 0xF0)
    function automatic logic [7:0] dflt(input logic [11:0] a);
        if (a == 12'h050) return 8'hF0;
        return 8'(a * 13 + 5);
    endfunction

    // Behavioural BRAM: 1-cycle read latency
    bit         wflag [4096];
    logic [7:0] wdat  [4096];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_write) begin
                wflag[mem_addr] <= 1'b1;
                wdat[mem_addr]  <= mem_wdata;
            end else begin
                mem_rdata <= wflag[mem_addr] ? wdat[mem_addr] : dflt(mem_addr);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    int         m_owner;          // -1 = nobody owns the port
    int         m_cnt;            // grants so far in the current tenure
    int         m_last;           // requester that owned most recently
    bit         m_pv [2];
    logic [7:0] m_pd [2];
    logic [7:0] m_mem [4096];
    logic       e_gnt [2];
    logic       e_en, e_wr;
    logic [11:0] e_addr;
    logic [7:0]  e_wd;

    // sampled DUT outputs of the most recent cycle
    logic       s_g0, s_g1, s_rv0, s_rv1, s_en;
    logic [7:0] s_rd0, s_rd1;
    logic [11:0] s_addr;

    task automatic model_reset();
        m_owner = -1; m_cnt = 0; m_last = 1;
        m_pv[0] = 0;  m_pv[1] = 0;
    endtask

    task automatic model_eval();
        e_gnt[0] = 0; e_gnt[1] = 0;
        e_en = 0; e_wr = 0; e_addr = '0; e_wd = '0;
        if (m_owner >= 0) begin
            e_gnt[m_owner] = req[m_owner];
            e_en   = req[m_owner];
            e_wr   = req[m_owner] & we[m_owner];
            e_addr = ad[m_owner];
            e_wd   = wd[m_owner];
        end
    endtask

    task automatic model_step();
        int o;
        for (int x = 0; x < 2; x++) begin
            m_pv[x] = e_gnt[x] && !we[x];
            if (m_pv[x]) m_pd[x] = m_mem[ad[x]];
        end
        if (e_wr) m_mem[e_addr] = e_wd;
        if (m_owner < 0) begin
            m_cnt = 0;
            if (req[0] && req[1]) begin
`ifdef MEM_ARB_RR_EN
                m_owner = 1 - m_last;
`else
                m_owner = 0;
`endif
            end else if (req[0]) m_owner = 0;
            else if (req[1])     m_owner = 1;
        end else begin
            o = 1 - m_owner;
            m_last = m_owner;
            if (!req[m_owner]) begin
                m_owner = req[o] ? o : -1;
                m_cnt   = 0;
            end else if (m_cnt == MAXB - 1 && req[o]) begin
                m_owner = o;
                m_cnt   = 0;
            end else if (m_cnt < MAXB - 1) begin
                m_cnt++;
            end
        end
    endtask

    // One clock cycle: drive, compare against the model, advance the model
    task automatic cyc(input logic q0, input logic w0, input logic [11:0] a0, input logic [7:0] d0,
                       input logic q1, input logic w1, input logic [11:0] a1, input logic [7:0] d1);
        @(negedge clk);
        req[0] = q0; we[0] = w0; ad[0] = a0; wd[0] = d0;
        req[1] = q1; we[1] = w1; ad[1] = a1; wd[1] = d1;
        #1;
        model_eval();
        s_g0 = r0_gnt; s_g1 = r1_gnt; s_rv0 = r0_rvalid; s_rv1 = r1_rvalid;
        s_rd0 = r0_rdata; s_rd1 = r1_rdata; s_en = mem_en; s_addr = mem_addr;
        chk("gnt0", 32'(r0_gnt), 32'(e_gnt[0]));
        chk("gnt1", 32'(r1_gnt), 32'(e_gnt[1]));
        chk("gnt_excl", 32'(r0_gnt & r1_gnt), 32'd0);
        chk("mem_en", 32'(mem_en), 32'(e_en));
        chk("mem_write", 32'(mem_write), 32'(e_wr));
        if (e_en) begin
            chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
        end
        chk("rvalid0", 32'(r0_rvalid), 32'(m_pv[0]));
        chk("rvalid1", 32'(r1_rvalid), 32'(m_pv[1]));
        chk("rdata0", 32'(r0_rdata), m_pv[0] ? 32'(m_pd[0]) : 32'd0);
        chk("rdata1", 32'(r1_rdata), m_pv[1] ? 32'(m_pd[1]) : 32'd0);
        @(posedge clk);
        model_step();
    endtask

    task automatic idle();
        cyc(0, 0, 12'h0, 8'h0, 0, 0, 12'h0, 8'h0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},  32'({r0_gnt, r1_gnt}), 32'd0);
        chk({tag, "_rv"},   32'({r0_rvalid, r1_rvalid}), 32'd0);
        chk({tag, "_mem"},  32'({mem_en, mem_write, mem_addr, mem_wdata}), 32'd0);
        chk({tag, "_rd"},   32'({r0_rdata, r1_rdata}), 32'd0);
    endtask

    logic        h_req [2];
    logic        h_we  [2];
    logic [11:0] h_ad  [2];
    logic [7:0]  h_wd  [2];

    initial begin
        for (int i = 0; i < 4096; i++) m_mem[i] = dflt(12'(i));
        for (int x = 0; x < 2; x++) begin
            req[x] = 0; we[x] = 0; ad[x] = '0; wd[x] = '0;
        end
        model_reset();
        rst_n = 1'b0;
        #1;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single read of the font byte from IDLE
        cyc(1, 0, 12'h050, 8'h00, 0, 0, 12'h0, 8'h0);
        chk("rd_latency_gnt", 32'(s_g0), 32'd0);
        cyc(1, 0, 12'h050, 8'h00, 0, 0, 12'h0, 8'h0);
        chk("rd_gnt", 32'(s_g0), 32'd1);
        chk("rd_addr", 32'(s_addr), 32'h050);
        idle();
        chk("rd_rvalid", 32'(s_rv0), 32'd1);
        chk("rd_data", 32'(s_rd0), 32'hF0);
        idle();

        // r1 write then read back
        cyc(0, 0, 12'h0, 8'h0, 1, 1, 12'h200, 8'hA5);
        cyc(0, 0, 12'h0, 8'h0, 1, 1, 12'h200, 8'hA5);
        chk("wr_gnt", 32'(s_g1), 32'd1);
        cyc(0, 0, 12'h0, 8'h0, 1, 0, 12'h200, 8'h00);
        chk("wr_no_rvalid", 32'(s_rv1), 32'd0);
        idle();
        chk("rb_rvalid", 32'(s_rv1), 32'd1);
        chk("rb_data", 32'(s_rd1), 32'hA5);
        idle();

        // Contention: r0 wins the first tie (r1 owned last), bursts of MAXB
        for (int k = 0; k <= 16; k++) begin
            cyc(1, 0, 12'h300, 8'h0, 1, 0, 12'h301, 8'h0);
            chk($sformatf("burst_g0_%0d", k), 32'(s_g0),
                32'(k >= 1 && ((k - 1) / MAXB) % 2 == 0));
            chk($sformatf("burst_g1_%0d", k), 32'(s_g1),
                32'(k >= 1 && ((k - 1) / MAXB) % 2 == 1));
            if (k == MAXB + 1) begin
                chk("handover_rv0", 32'(s_rv0), 32'd1);
                chk("handover_en", 32'(s_en), 32'd1);
            end
        end
        idle();
        idle();

        // Tie after r0 owned last: RR gives r1, fixed priority gives r0
        cyc(1, 0, 12'h050, 8'h0, 0, 0, 12'h0, 8'h0);
        cyc(1, 0, 12'h050, 8'h0, 0, 0, 12'h0, 8'h0);
        idle();
        cyc(1, 0, 12'h010, 8'h0, 1, 0, 12'h020, 8'h0);
        cyc(1, 0, 12'h010, 8'h0, 1, 0, 12'h020, 8'h0);
`ifdef MEM_ARB_RR_EN
        chk("tie_winner", 32'({s_g1, s_g0}), 32'b10);
`else
        chk("tie_winner", 32'({s_g1, s_g0}), 32'b01);
`endif
        idle();
        idle();

        // Reset in the cycle after a granted read
        cyc(1, 0, 12'h050, 8'h0, 0, 0, 12'h0, 8'h0);
        cyc(1, 0, 12'h050, 8'h0, 0, 0, 12'h0, 8'h0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrd_rst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #1;
        chk_all_zero("midrd_rst2");
        req[0] = 0; req[1] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        chk("post_rst_rv", 32'({s_rv1, s_rv0}), 32'd0);
        cyc(1, 0, 12'h050, 8'h0, 0, 0, 12'h0, 8'h0);
        chk("post_rst_lat", 32'(s_g0), 32'd0);
        cyc(1, 0, 12'h050, 8'h0, 0, 0, 12'h0, 8'h0);
        chk("post_rst_gnt", 32'(s_g0), 32'd1);
        idle();
        chk("post_rst_data", 32'(s_rd0), 32'hF0);

        // Randomised traffic; requesters hold until granted, may cancel
        for (int x = 0; x < 2; x++) begin
            h_req[x] = 0; h_we[x] = 0; h_ad[x] = '0; h_wd[x] = '0;
        end
        for (int n = 0; n < 1000; n++) begin
            cyc(h_req[0], h_we[0], h_ad[0], h_wd[0], h_req[1], h_we[1], h_ad[1], h_wd[1]);
            for (int x = 0; x < 2; x++) begin
                if (!h_req[x] || e_gnt[x] || $urandom_range(15) == 0) begin
                    h_req[x] = ($urandom_range(9) < 7);
                    h_we[x]  = ($urandom_range(9) < 3);
                    h_ad[x]  = 12'h200 + 12'($urandom_range(15));
                    h_wd[x]  = 8'($urandom);
                end
            end
        end
        idle();
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_chip8_mem_arbiter
`default_nettype wire
